// File: rtl/vend_session_ctrl.sv
// Coin-operated vending session controller: credit tracking, vend, change, refund and stock.
// Optional: define VEND_SALES_CNT_EN to add a saturating 16-bit sales counter output.
module vend_session_ctrl #(
    parameter int PRICE_UNITS = 4,
    parameter int STOCK_MAX   = 8,
    parameter int TIMEOUT     = 16,
    localparam int CW = $clog2(PRICE_UNITS + 2),
    localparam int SW = $clog2(STOCK_MAX + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          restock,
    output logic          dispense,
    output logic          chg5,
    output logic          ret5,
    output logic          coin_rej,
    output logic          sold_out,
    output logic [CW-1:0] credit,
    output logic [SW-1:0] stock
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [15:0]   sales_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_REFUND = 2'd3;

    logic [1:0]    state, state_nx;
    logic [CW-1:0] credit_nx, credit_sum, coin_val;
    logic [SW-1:0] stock_nx;
    logic [TW-1:0] idle_cnt, idle_nx, idle_inc;
    logic          coin_ok, dispense_nx, chg5_nx;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx    = state;
        credit_nx   = credit;
        stock_nx    = stock;
        idle_nx     = '0;
        dispense_nx = 1'b0;
        chg5_nx     = 1'b0;
        coin_ok     = (state == S_IDLE || state == S_CREDIT) && (stock != '0) &&
                      (coin == 2'b01 || coin == 2'b10);
        coin_val    = (coin == 2'b10) ? CW'(2) : CW'(1);
        credit_sum  = credit + coin_val;
        idle_inc    = idle_cnt + TW'(1);

        case (state)
            S_IDLE, S_CREDIT: begin
                if (coin_ok) begin
                    if (credit_sum >= CW'(PRICE_UNITS)) begin
                        state_nx    = S_VEND;
                        credit_nx   = '0;
                        stock_nx    = stock - SW'(1);
                        dispense_nx = 1'b1;
                        chg5_nx     = (credit_sum == CW'(PRICE_UNITS + 1));
                    end else begin
                        // A coin arriving with cancel is credited before the refund starts.
                        credit_nx = credit_sum;
                        state_nx  = (state == S_CREDIT && cancel) ? S_REFUND : S_CREDIT;
                    end
                end else if (state == S_CREDIT) begin
                    if (cancel || idle_inc == TW'(TIMEOUT)) begin
                        state_nx = S_REFUND;
                    end else begin
                        idle_nx = idle_inc;
                    end
                end
            end
            S_VEND: state_nx = S_IDLE;
            default: begin
                credit_nx = credit - CW'(1);
                if (credit == CW'(1)) begin
                    state_nx = S_IDLE;
                end
            end
        endcase

        if (restock) begin
            stock_nx = SW'(STOCK_MAX);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers update with <= so every flop samples the pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            credit   <= '0;
            stock    <= SW'(STOCK_MAX);
            idle_cnt <= '0;
            dispense <= 1'b0;
            chg5     <= 1'b0;
            ret5     <= 1'b0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nx;
            credit   <= credit_nx;
            stock    <= stock_nx;
            idle_cnt <= idle_nx;
            dispense <= dispense_nx;
            chg5     <= chg5_nx;
            ret5     <= (state_nx == S_REFUND);
            coin_rej <= (coin != 2'b00) && !coin_ok;
        end
    end

    assign sold_out = (stock == '0);

`ifdef VEND_SALES_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sales_cnt <= '0;
        end else if (dispense_nx && sales_cnt != 16'hFFFF) begin
            sales_cnt <= sales_cnt + 16'd1;
        end
    end
`endif

endmodule
